// File: rtl/counter_pkg.sv
// Mode encodings shared by the multi-mode counter and its next-state logic.
package counter_pkg;

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_RING    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

endpackage

// File: rtl/counter_next_logic.sv
// Combinational successor function of the counter: given the present count and
// mode, produce the value for the next enabled edge and whether it is terminal.
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter longint      MODULUS  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             term_o
);

    // Truncation makes MODULUS = 2**WIDTH compare against all-ones.
    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] john_next;

    assign rot_left[0]  = count_i[WIDTH-1];
    assign john_next[0] = ~count_i[WIDTH-1];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign rot_left[gi]  = count_i[gi-1];
            assign john_next[gi] = count_i[gi-1];
        end
    endgenerate

    always_comb begin
        next_count_o = count_i;
        term_o       = 1'b0;
        case (mode_i)
            MODE_UP: begin
                if (count_i >= MOD_MAX) begin
                    term_o       = 1'b1;
                    next_count_o = SATURATE ? count_i : '0;
                end else begin
                    next_count_o = count_i + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (count_i == '0) begin
                    term_o       = 1'b1;
                    next_count_o = SATURATE ? '0 : MOD_MAX;
                end else begin
                    next_count_o = count_i - WIDTH'(1);
                end
            end
            MODE_RING: begin
                // Anything other than a single set bit re-seeds the ring.
                if (!$onehot(count_i)) begin
                    next_count_o = WIDTH'(1);
                end else begin
                    next_count_o = rot_left;
                    term_o       = count_i[WIDTH-1];
                end
            end
            MODE_JOHNSON: begin
                next_count_o = john_next;
                term_o       = (john_next == '0);
            end
            default: begin
                next_count_o = count_i;
                term_o       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_mode_counter.sv
// Parametrised up/down/ring/Johnson counter with synchronous load, enable,
// optional saturation and a registered terminal-count pulse.
module multi_mode_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_count;
    logic             step_term;

    counter_next_logic #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i      (count_q),
        .mode_i       (mode),
        .next_count_o (step_count),
        .term_o       (step_term)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = step_count;
            tc_d    = step_term;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
Parametrised counter; successor to the fixed 4-bit up counter. Adds programmable width and modulus, up/down/ring/Johnson modes, synchronous load, count enable, optional saturation and a registered terminal-count pulse. Drop-in counting primitive for timers, sequencers and the all-in-one counter top.

Parameters:
WIDTH, 4, counter width in bits; legal range 2 to 32.
MODULUS, 16, up/down cycle length; legal range 2 to 2**WIDTH; ignored in ring and Johnson modes.
SATURATE, 0, 1 = up/down hold at the terminal value instead of wrapping.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
clear  in  1  reset, asynchronous, active-low.
en  in  1  count enable; 1 = step one count per clock.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value loaded when load=1.
mode  in  2  00 up, 01 down, 10 ring, 11 Johnson.
count  out  WIDTH  registered counter value.
tc  out  1  registered terminal-count pulse.

Behaviour:
- Reset: clear=0 forces count=0 and tc=0 immediately, with no clock edge needed; both are held while clear=0. The first enabled edge after release steps from 0.
- Priority per edge: load > en step > hold.
- Load: count <= load_val, taken regardless of en or mode. tc <= 0. Loaded value is not range-checked.
- en=0 and load=0: count holds; tc <= 0.
- Up mode (en=1):
  - count < MODULUS-1: count+1.
  - count >= MODULUS-1: terminal. Next value is 0, or holds if SATURATE=1. tc <= 1.
- Down mode (en=1):
  - count > 0: count-1.
  - count == 0: terminal. Next value is MODULUS-1, or holds 0 if SATURATE=1. tc <= 1.
  - A loaded value >= MODULUS decrements normally.
- Ring mode (en=1):
  - count not one-hot (includes 0): count <= 1, tc <= 0. This self-corrects the state.
  - Otherwise rotate left: {count[WIDTH-2:0], count[WIDTH-1]}.
  - tc <= 1 on the MSB-to-bit0 rotation.
- Johnson mode (en=1):
  - count <= {count[WIDTH-2:0], ~count[WIDTH-1]}.
  - tc <= 1 when the next value is all-zero (period 2*WIDTH).
  - Illegal Johnson states are not corrected.
- tc is a one-cycle registered pulse, asserted on the same edge the terminal transition is written to count. With SATURATE=1 it stays high on every enabled cycle spent at the terminal value.
- Mode change mid-count: takes effect on the next enabled edge. count is not reset or reinterpreted.
- Arithmetic: WIDTH-bit unsigned. The comparison with MODULUS-1 uses WIDTH bits. MODULUS = 2**WIDTH gives natural binary wrap.
- Latency: count and tc change one edge after en or load is sampled.

Decomposition:
- Shared package counter_pkg holds the mode encodings as localparams: MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_RING=2'b10, MODE_JOHNSON=2'b11.
- Natural sub-module: counter_next_logic. It is purely combinational: takes (count, mode) and produces (next_count, term). The top keeps only the registers, load/enable priority and async clear.

Test Plan:
1. WIDTH=4, MODULUS=10, up, en=1 from clear release, 11 edges -> count 1..9, then 0 with tc=1 on that edge only, then 1.
2. SATURATE=1, MODULUS=10, load_val=2, then down with en=1 -> count 1, 0, 0, 0. tc=0, 0, 1, 1. Switch to up -> count 1, tc=0.
3. Up counting reaches count=7; drive clear low mid-cycle -> count=0 and tc=0 before the next clk edge. Release clear, en=1 -> count 1.
4. Ring mode from count=0 -> 0001, 0010, 0100, 1000, 0001, with tc=1 only on the 1000->0001 edge. load_val=0110 then en -> 0001, tc=0.
5. Johnson mode from 0 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with tc=1 only on the edge entering 0000.
6. Priority:
   - en=0, load=1, load_val=5 -> count=5.
   - en=1 and load=1 with load_val=3 in up mode -> count=3, not 6.
   - Hold: en=0, load=0 for 4 cycles -> count stays 3, tc=0.
